// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier arbiter.
package booth_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_RESP
   } state_e;

   localparam int DEF_N            = 8;
   localparam int DEF_START_CYCLES = 2;
   localparam int DEF_TIMEOUT      = 64;

   // Ceiling log2, usable in constant expressions; returns 0 for v <= 1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int k = 0; k < 31; k++) begin
         if ((1 << r) < v) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/booth_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter
   import booth_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]        req_i,
   input  logic [clog2(NREQ)-1:0] ptr_i,
   output logic                   valid_o,
   output logic [clog2(NREQ)-1:0] idx_o
);

   localparam int IW = clog2(NREQ);

   logic [IW-1:0] cand;

   // Scan from the farthest offset down so the closest request to ptr wins.
   always_comb begin
      valid_o = |req_i;
      idx_o   = '0;
      cand    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = ptr_i + IW'(k);
         if (req_i[cand]) idx_o = cand;
      end
   end

endmodule

// File: rtl/booth_arbiter.sv
// Shares one Booth multiplier core between NREQ requesters with round-robin
// grant, Start/Done sequencing, product capture and a Done watchdog.
module booth_arbiter
   import booth_pkg::*;
#(
   parameter int N            = DEF_N,
   parameter int NREQ         = 4,
   parameter int START_CYCLES = DEF_START_CYCLES,
   parameter int TIMEOUT      = DEF_TIMEOUT
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NREQ-1:0]         req_i,
   input  logic [NREQ*N-1:0]       req_mplier_i,
   input  logic [NREQ*N-1:0]       req_mcand_i,
   output logic [NREQ-1:0]         ack_o,
   output logic [2*N-1:0]          result_o,
   output logic                    err_o,
   output logic                    busy_o,
   output logic [clog2(NREQ)-1:0]  grant_id_o,
   output logic [N-1:0]            core_mplier_o,
   output logic [N-1:0]            core_mcand_o,
   output logic                    core_start_o,
   input  logic                    core_done_i,
   input  logic [2*N-1:0]          core_product_i
);

   localparam int IW = clog2(NREQ);
   localparam int SW = clog2(START_CYCLES) + 1;
   localparam int WW = clog2(TIMEOUT) + 1;

   state_e          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   gid_q, gid_d;
   logic [N-1:0]    mpl_q, mpl_d;
   logic [N-1:0]    mcd_q, mcd_d;
   logic [SW-1:0]   scnt_q, scnt_d;
   logic [WW-1:0]   wdog_q, wdog_d;
   logic [2*N-1:0]  prod_q, prod_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [2*N-1:0]  res_q, res_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;
   logic            start_q, start_d;

   logic            pick_vld;
   logic [IW-1:0]   pick_idx;
   logic            to_resp;
   logic            to_err;
   logic            wdog_exp;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .valid_o (pick_vld),
      .idx_o   (pick_idx)
   );

   assign wdog_exp = (wdog_q == WW'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      mpl_d   = mpl_q;
      mcd_d   = mcd_q;
      scnt_d  = scnt_q;
      wdog_d  = wdog_q;
      prod_d  = prod_q;
      res_d   = res_q;
      err_d   = err_q;
      ack_d   = '0;
      to_resp = 1'b0;
      to_err  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               gid_d   = pick_idx;
               mpl_d   = req_mplier_i[int'(pick_idx)*N +: N];
               mcd_d   = req_mcand_i[int'(pick_idx)*N +: N];
               scnt_d  = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (scnt_q == SW'(START_CYCLES - 1)) begin
               wdog_d  = '0;
               state_d = ST_WAIT_HI;
            end else begin
               scnt_d = scnt_q + SW'(1);
            end
         end
         ST_WAIT_HI: begin
            if (core_done_i) begin
               prod_d  = core_product_i;
               wdog_d  = '0;
               state_d = ST_WAIT_LO;
            end else if (wdog_exp) begin
               to_resp = 1'b1;
               to_err  = 1'b1;
            end else begin
               wdog_d = wdog_q + WW'(1);
            end
         end
         ST_WAIT_LO: begin
            if (!core_done_i) begin
               to_resp = 1'b1;
            end else if (wdog_exp) begin
               to_resp = 1'b1;
               to_err  = 1'b1;
            end else begin
               wdog_d = wdog_q + WW'(1);
            end
         end
         ST_RESP: begin
            ptr_d   = gid_q + IW'(1);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Response fields are registered on entry so they are valid in RESP.
      if (to_resp) begin
         state_d      = ST_RESP;
         ack_d[gid_q] = 1'b1;
         err_d        = to_err;
         res_d        = to_err ? '0 : prod_q;
      end

      start_d = (state_d == ST_START);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         mpl_q   <= '0;
         mcd_q   <= '0;
         scnt_q  <= '0;
         wdog_q  <= '0;
         prod_q  <= '0;
         ack_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         mpl_q   <= mpl_d;
         mcd_q   <= mcd_d;
         scnt_q  <= scnt_d;
         wdog_q  <= wdog_d;
         prod_q  <= prod_d;
         ack_q   <= ack_d;
         res_q   <= res_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         start_q <= start_d;
      end
   end

   assign ack_o         = ack_q;
   assign result_o      = res_q;
   assign err_o         = err_q;
   assign busy_o        = busy_q;
   assign grant_id_o    = gid_q;
   assign core_mplier_o = mpl_q;
   assign core_mcand_o  = mcd_q;
   assign core_start_o  = start_q;

endmodule

// File: tb/tb_booth_arbiter.sv
// Randomized and directed bench for booth_arbiter with a behavioural core.
module tb_booth_arbiter;

   localparam int N    = 8;
   localparam int NREQ = 4;
   localparam int TO   = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*N-1:0] req_mpl = '0;
   logic [NREQ*N-1:0] req_mcd = '0;
   logic [NREQ-1:0]   ack;
   logic [2*N-1:0]    result;
   logic              err;
   logic              busy;
   logic [1:0]        grant_id;
   logic [N-1:0]      core_mpl;
   logic [N-1:0]      core_mcd;
   logic              core_start;
   logic              core_done;
   logic [2*N-1:0]    core_prod;

   always #5 clk = ~clk;

   booth_arbiter #(.N(N), .NREQ(NREQ), .START_CYCLES(2), .TIMEOUT(TO)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_i          (req),
      .req_mplier_i   (req_mpl),
      .req_mcand_i    (req_mcd),
      .ack_o          (ack),
      .result_o       (result),
      .err_o          (err),
      .busy_o         (busy),
      .grant_id_o     (grant_id),
      .core_mplier_o  (core_mpl),
      .core_mcand_o   (core_mcd),
      .core_start_o   (core_start),
      .core_done_i    (core_done),
      .core_product_i (core_prod)
   );

   // Behavioural core: 0 = normal, 1 = never Done, 2 = Done already high.
   int core_mode = 0;
   int dly = 0;
   int hi  = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rst) begin
         core_done <= 1'b0;
         dly       <= 0;
         hi        <= 0;
      end else if (core_start) begin
         core_prod <= 16'($signed(core_mpl) * $signed(core_mcd));
         if (core_mode == 2) begin
            core_done <= 1'b1;
            hi        <= 4;
         end else begin
            core_done <= 1'b0;
            dly       <= (core_mode == 0) ? 11 : 0;
         end
      end else begin
         if (dly > 0) begin
            dly <= dly - 1;
            if (dly == 1) begin
               core_done <= 1'b1;
               hi        <= 2;
            end
         end
         if (hi > 0) begin
            hi <= hi - 1;
            if (hi == 1) core_done <= 1'b0;
         end
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   logic [N-1:0] mpl [NREQ];
   logic [N-1:0] mcd [NREQ];
   int ptr_m = 0;

   function automatic logic [15:0] exp_prod(input logic [7:0] a, input logic [7:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return p[15:0];
   endfunction

   function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
      mpl[i] = a;
      mcd[i] = b;
      req_mpl[i*N +: N] = a;
      req_mcd[i*N +: N] = b;
      req[i] = 1'b1;
   endtask

   task automatic wait_ack(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (ack != '0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("ack_wait_timeout", 0, 1);
   endtask

   // Waits for the first cycle with core_start low after it was high.
   task automatic find_wait_hi(output int entry);
      bit seen;
      seen  = 1'b0;
      entry = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (core_start) seen = 1'b1;
         else if (seen) begin
            entry = cyc;
            break;
         end
      end
      if (entry < 0) chk("start_fall_timeout", 0, 1);
   endtask

   task automatic serve(input int e, input string tag);
      bit ok;
      wait_ack(ok);
      chk({tag, "_ack"}, 32'(ack), 32'(1 << e));
      chk({tag, "_gid"}, 32'(grant_id), 32'(e));
      chk({tag, "_res"}, 32'(result), 32'(exp_prod(mpl[e], mcd[e])));
      chk({tag, "_err"}, 32'(err), 0);
      req[e] = 1'b0;
      ptr_m  = (e + 1) % NREQ;
   endtask

   task automatic watch_no_ack(input int n, input string tag);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (ack != '0) seen = 1'b1;
      end
      chk(tag, 32'(seen), 0);
   endtask

   logic [15:0] sim_res [4] = '{16'h000F, 16'hFFF1, 16'h4000, 16'hFFFF};
   int          fair_seq [4] = '{0, 2, 0, 2};

   initial begin
      int entry;
      bit ok;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_start", 32'(core_start), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_gid", 32'(grant_id), 0);
      rst = 1'b0;
      @(negedge clk);

      // Single request: start pulse timing and result
      set_req(0, 8'h03, 8'h05);
      @(negedge clk);
      chk("single_start_c1", 32'(core_start), 1);
      @(negedge clk);
      chk("single_start_c2", 32'(core_start), 1);
      @(negedge clk);
      chk("single_start_c3", 32'(core_start), 0);
      serve(0, "single");
      chk("single_res_lit", 32'(result), 32'h000F);
      @(negedge clk);
      chk("single_ack_pulse", 32'(ack), 0);
      chk("single_res_hold", 32'(result), 32'h000F);

      // Reset in the middle of WAIT_HI
      set_req(1, 8'h07, 8'h09);
      find_wait_hi(entry);
      repeat (3) @(negedge clk);
      chk("mid_busy", 32'(busy), 1);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      chk("midrst_start", 32'(core_start), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_ack", 32'(ack), 0);
      chk("midrst_result", 32'(result), 0);
      @(negedge clk);
      rst   = 1'b0;
      ptr_m = 0;
      watch_no_ack(40, "midrst_stale_ack");

      // Simultaneous requests
      set_req(0, 8'h03, 8'h05);
      set_req(1, 8'hFD, 8'h05);
      set_req(2, 8'h80, 8'h80);
      set_req(3, 8'hFF, 8'h01);
      for (int j = 0; j < 4; j++) begin
         serve(j, "sim");
         chk("sim_res_lit", 32'(result), 32'(sim_res[j]));
      end

      // Fairness: requester 0 re-requests immediately, 2 keeps asking
      set_req(0, 8'($urandom), 8'($urandom));
      set_req(2, 8'($urandom), 8'($urandom));
      for (int j = 0; j < 4; j++) begin
         chk("fair_model", 32'(rr_pick(req, ptr_m)), 32'(fair_seq[j]));
         serve(fair_seq[j], "fair");
         if (j < 3) set_req(fair_seq[j], 8'($urandom), 8'($urandom));
      end
      serve(0, "fair_drain");

      // Timeout with a hung core, then a normal follow-up on the same requester
      core_mode = 1;
      set_req(1, 8'h11, 8'h22);
      find_wait_hi(entry);
      wait_ack(ok);
      chk("to_latency", 32'(cyc - entry), TO);
      chk("to_ack", 32'(ack), 32'b0010);
      chk("to_err", 32'(err), 1);
      chk("to_result", 32'(result), 0);
      ptr_m     = 2;
      core_mode = 0;
      set_req(1, 8'hF0, 8'h0C);
      serve(1, "to_follow");

      // Done already high when start ends
      core_mode = 2;
      set_req(3, 8'hE7, 8'h2B);
      serve(3, "early");
      watch_no_ack(30, "early_single_ack");
      core_mode = 0;

      // Randomized traffic against the round-robin model
      for (int r = 0; r < 24; r++) begin
         int e;
         for (int i = 0; i < NREQ; i++)
            if (!req[i] && ($urandom_range(1, 0) == 1))
               set_req(i, 8'($urandom), 8'($urandom));
         if (req == '0) begin
            int i;
            i = $urandom_range(NREQ - 1, 0);
            set_req(i, 8'($urandom), 8'($urandom));
         end
         e = rr_pick(req, ptr_m);
         serve(e, "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
